// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one registered bitwise logic unit among N_REQ requesters
module logic_unit_arbiter #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  input  logic                   rsp_ready,
  output logic [15:0]            ops_done
);
  typedef enum logic {IDLE, RESP} state_e;
  state_e          state_q;
  logic [ID_W-1:0] ptr_q, ptr_d, rsp_id_q, win, idx;
  logic [WIDTH-1:0] rsp_data_q, data_d;
  logic [15:0]     ops_done_q;
  logic [1:0]      op_v [N_REQ];
  logic [WIDTH-1:0] a_v [N_REQ];
  logic [WIDTH-1:0] b_v [N_REQ];
  logic            found, accept_ok, accept;
  genvar g;
  for (g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_v[g] = req_op[2*g +: 2];
    assign a_v[g]  = req_a[WIDTH*g +: WIDTH];
    assign b_v[g]  = req_b[WIDTH*g +: WIDTH];
  end
  // winner search from ptr upward; scanning backwards lets the closest valid requester overwrite the rest
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  assign accept_ok = reset && (state_q == IDLE || rsp_ready);
  assign accept    = accept_ok && found;
  assign req_ready = accept ? (N_REQ'(1) << win) : '0;
  assign ptr_d     = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
  // the logic unit itself: every op code is defined
  always_comb begin
    data_d = op_v[win] == 2'b00 ? (a_v[win] & b_v[win]) :
             op_v[win] == 2'b01 ? (a_v[win] | b_v[win]) :
             op_v[win] == 2'b10 ? (a_v[win] ^ b_v[win]) : ~(a_v[win] & b_v[win]);
  end
  // response FSM, result register, grant pointer and completion counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      ptr_q      <= '0;
      ops_done_q <= '0;
    end else begin
      if (state_q == RESP && rsp_ready) ops_done_q <= ops_done_q + 16'd1;
      if (accept) begin
        state_q    <= RESP;
        rsp_id_q   <= win;
        rsp_data_q <= data_d;
        ptr_q      <= ptr_d;
      end else if (rsp_ready) begin
        state_q <= IDLE;
      end
    end
  end
  assign rsp_valid = state_q == RESP;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign ops_done  = ops_done_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: scoreboard bench with a behavioural arbitration model
module tb_logic_unit_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] rv;
  logic [2*N-1:0] rop;
  logic [W*N-1:0] ra, rb;
  logic [N-1:0] req_ready;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_data;
  logic rready;
  logic [15:0] ops_done;
  int total = 0;
  int bad = 0;
  int ptr = 0;
  bit held = 0;
  logic [15:0] cnt = '0;
  logic [17:0] q[$];

  logic_unit_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(rv), .req_op(rop), .req_a(ra), .req_b(rb),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rready), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] lu(logic [1:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic set_req(int i, logic [1:0] op, logic [15:0] a, logic [15:0] b);
    rop[2*i +: 2] = op;
    ra[W*i +: W] = a;
    rb[W*i +: W] = b;
  endtask

  // one clock: compare against the model at negedge, advance the model, return just after the edge
  task automatic step();
    int w;
    bit acc;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && rv[(ptr + k) % N]) w = (ptr + k) % N;
    acc = reset && w >= 0 && (!held || rready);
    exp_rdy = acc ? N'(1) << w : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(held));
    chk("ops_done", 32'(ops_done), 32'(cnt));
    if (!reset) begin
      held = 0; ptr = 0; cnt = '0; q.delete();
    end else begin
      if (held && rready) cnt++;
      if (acc) begin
        q.push_back({2'(w), lu(rop[2*w +: 2], ra[W*w +: W], rb[W*w +: W])});
        ptr = (w + 1) % N;
        held = 1;
      end else if (rready) held = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: checks every presented response against the oldest expected one
  initial begin
    forever begin
      @(negedge clk);
      if (reset && rsp_valid) begin
        if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          chk("rsp_id", 32'(rsp_id), 32'(q[0][17:16]));
          chk("rsp_data", 32'(rsp_data), 32'(q[0][15:0]));
          if (rready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 0; rv = '0; rop = '0; ra = '0; rb = '0; rready = 1;
    @(posedge clk);
    #1;
    step();
    step();
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    reset = 1;
    set_req(1, 2'b00, 16'hF0F0, 16'hFF00);
    rv = 4'b0010;
    #1 chk("single_ready", 32'(req_ready), 32'h2);
    step();
    rv = '0;
    #1;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_id", 32'(rsp_id), 32'd1);
    chk("single_data", 32'(rsp_data), 32'hF000);
    step();
    chk("single_count", 32'(ops_done), 32'd1);
    for (int op = 0; op < 4; op++) begin
      set_req(0, 2'(op), 16'h00FF, 16'h0F0F);
      rv = 4'b0001;
      step();
    end
    rv = '0;
    step();
    for (int i = 0; i < N; i++) set_req(i, 2'(i), 16'(16'h1111 * (i + 1)), 16'h5A5A);
    rv = 4'b1111;
    for (int i = 0; i < 8; i++) step();
    rv = '0;
    step();
    chk("rr_count", 32'(ops_done), 32'd13);
    rv = 4'b0100;
    set_req(2, 2'b10, 16'hBEEF, 16'h1234);
    step();
    rready = 0;
    rv = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      set_req(3, 2'($urandom), 16'($urandom), 16'($urandom));
      step();
      chk("bp_id", 32'(rsp_id), 32'd2);
      chk("bp_data", 32'(rsp_data), 32'(16'hBEEF ^ 16'h1234));
    end
    rready = 1;
    #1 chk("bp_release", 32'(req_ready), 32'h8);
    step();
    rready = 0;
    step();
    reset = 0;
    step();
    chk("midreset_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_data", 32'(rsp_data), 32'd0);
    chk("midreset_count", 32'(ops_done), 32'd0);
    reset = 1;
    rready = 1;
    rv = 4'b1001;
    #1 chk("midreset_grant", 32'(req_ready), 32'h1);
    step();
    for (int i = 0; i < 400; i++) begin
      rv = N'($urandom);
      for (int j = 0; j < N; j++) set_req(j, 2'($urandom), 16'($urandom), 16'($urandom));
      rready = ($urandom % 4) != 0;
      reset = (i != 250);
      step();
    end
    reset = 0;
    rv = '0;
    rready = 1;
    step();
    reset = 1;
    rv = 4'b0001;
    set_req(0, 2'b11, 16'hA5A5, 16'h0FF0);
    while (cnt != 16'hFFFF) step();
    chk("wrap_top", 32'(ops_done), 32'hFFFF);
    step();
    chk("wrap_zero", 32'(ops_done), 32'h0);
    rv = '0;
    step();
    step();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered 16-bit logic unit among N_REQ requesters using round-robin arbitration.
- Each requester presents an operation and two operands with a valid/ready handshake. Exactly one request is granted per accepted cycle.
- The result is returned on a single response channel, tagged with the requester ID.
- Sits between client blocks and the bitwise logic datapath; the datapath is instantiated inside this block.

Parameters:
- WIDTH, 16, operand/result width in bits.
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the requester ID (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  N_REQ  per-requester request valid.
- req_op  in  2*N_REQ  per-requester op; requester i uses bits [2i+1:2i].
- req_a  in  WIDTH*N_REQ  per-requester operand A; requester i uses slice i.
- req_b  in  WIDTH*N_REQ  per-requester operand B; requester i uses slice i.
- req_ready  out  N_REQ  one-hot grant; request i is accepted on a cycle where req_valid[i] && req_ready[i].
- rsp_valid  out  1  response valid.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  WIDTH  operation result.
- rsp_ready  in  1  downstream accepts the response.
- ops_done  out  16  count of responses accepted downstream; wraps 0xFFFF -> 0x0000.

Behaviour:
- Op encoding:
  - 00: A & B
  - 01: A | B
  - 10: A ^ B
  - 11: ~(A & B)
  - Every code is defined, so there is no default path and no latch.
- State machine, two states:
  - IDLE: no response held.
  - RESP: response held, rsp_valid = 1.
- accept_ok = (state == IDLE) || (state == RESP && rsp_ready).
- req_ready is combinational:
  - It is one-hot at the round-robin winner only when accept_ok && |req_valid.
  - Otherwise it is all zeros.
  - req_ready never asserts for a requester whose req_valid is 0.
- Round-robin pointer ptr (ID_W bits):
  - The winner is the first i with req_valid[i] = 1, searching ptr, ptr+1, ..., ptr+N_REQ-1 mod N_REQ.
  - On an accept, ptr <= (winner + 1) mod N_REQ.
  - ptr holds when there is no accept.
- On an accept (posedge):
  - rsp_data <= op(req_a[winner], req_b[winner]).
  - rsp_id <= winner.
  - state <= RESP.
  - Latency is 1 cycle: rsp_valid is high on the cycle after the accept.
- RESP with rsp_ready = 1:
  - ops_done increments.
  - If a new request is accepted in the same cycle, state stays RESP and rsp_data/rsp_id load the new result. This gives back-to-back throughput of 1 op/cycle.
  - Otherwise state <= IDLE.
- RESP with rsp_ready = 0:
  - rsp_valid, rsp_id and rsp_data are held stable.
  - req_ready is all zeros.
- Requester inputs are sampled only on the accept cycle. Changes on other cycles have no effect.
- Reset (reset == 0 at posedge), including mid-transaction:
  - state = IDLE, rsp_valid = 0, rsp_id = 0, rsp_data = 0, ptr = 0, ops_done = 0.
  - Any held response is discarded and not counted.
  - req_ready is forced to 0 while reset is low.
- Fairness: a requester holding req_valid high is granted within N_REQ accepts.

Test Plan:
- Reset, then a single request: reset low 2 cycles, then high. Requester 1 presents op=00, A=0xF0F0, B=0xFF00, with rsp_ready=1.
  - req_ready = 0010 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_id=1, rsp_data=0xF000.
  - ops_done=1 after the accept.
- All ops: requester 0 issues A=0x00FF, B=0x0F0F with op 00, 01, 10, 11 in turn.
  - Results: 0x000F, 0x0FFF, 0x0FF0, 0xFFF0.
- Round robin: all 4 requesters hold valid, with rsp_ready=1 continuously.
  - Grant order is 0, 1, 2, 3, 0, ... on consecutive cycles.
  - rsp_valid stays high every cycle after the first.
  - After 8 responses, ops_done=8.
- Backpressure: hold rsp_ready=0 for 5 cycles after a response from requester 2.
  - rsp_valid, rsp_id=2 and rsp_data are stable throughout.
  - req_ready = 0000 despite pending valids.
  - On release, the next grant goes to requester 3 if it is valid.
- Reset mid-operation: assert reset while in RESP with rsp_ready=0.
  - Next cycle: rsp_valid=0, rsp_data=0, ops_done=0, ptr=0.
  - After reset releases with requesters 0 and 3 valid, requester 0 is granted first.
- Counter wrap: preload via 65535 accepted responses, then one more.
  - ops_done goes 0xFFFF -> 0x0000.
